// File: rtl/md_unit_e.sv
// md_unit_e: E-stage multiply/divide unit owning HI/LO.
// Decodes mult/multu/div/divu/mfhi/mflo/mthi/mtlo from the E-stage instruction.
// Ports:
//    clk, reset        rising-edge clock, synchronous active-high reset
//    Instr_E_I         instruction currently in E
//    RD1_E_I, RD2_E_I  forwarded rs / rt operands
//    Req_I             exception taken; suppresses every side effect of the E instruction
//    Start_E_O         an MD operation is accepted at the next edge
//    Busy_E_O          an MD operation is in progress
//    HI_E_O, LO_E_O    architectural HI/LO
//    MDOut_E_O         HI for mfhi, LO for mflo, else 0
module md_unit_e #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr_E_I,
   input  logic [31:0] RD1_E_I,
   input  logic [31:0] RD2_E_I,
   input  logic        Req_I,
   output logic        Start_E_O,
   output logic        Busy_E_O,
   output logic [31:0] HI_E_O,
   output logic [31:0] LO_E_O,
   output logic [31:0] MDOut_E_O
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   logic [5:0]    funct;
   logic          is_r, is_md, is_mx, is_div, signed_op;
   logic          is_mfhi, is_mflo, is_mthi, is_mtlo;
   logic [31:0]   a, b, mag_a, mag_b, dvs, q, r, quo, rem;
   logic          neg_a, neg_b;
   logic [63:0]   ext_a, ext_b, prod, res, res_q;
   logic          res_we, res_we_q;
   logic [CW-1:0] cnt;
   logic          unused_bits;
   assign unused_bits = ^Instr_E_I[25:6];
   assign funct     = Instr_E_I[5:0];
   assign is_r      = Instr_E_I[31:26] == 6'b000000;
   // funct 0110xx are the MD starts, 0100xx the HI/LO moves
   assign is_md     = is_r && funct[5:2] == 4'b0110;
   assign is_mx     = is_r && funct[5:2] == 4'b0100;
   assign is_mfhi   = is_mx && funct[1:0] == 2'b00;
   assign is_mthi   = is_mx && funct[1:0] == 2'b01;
   assign is_mflo   = is_mx && funct[1:0] == 2'b10;
   assign is_mtlo   = is_mx && funct[1:0] == 2'b11;
   assign is_div    = funct[1];
   assign signed_op = ~funct[0];
   assign Start_E_O = is_md && !Busy_E_O && !Req_I;
   assign MDOut_E_O = is_mfhi ? HI_E_O : is_mflo ? LO_E_O : 32'd0;
   assign a = RD1_E_I;
   assign b = RD2_E_I;
   always_comb begin
      // Zero/sign-extend to 64 bits so one multiplier covers mult and multu
      ext_a = {{32{signed_op & a[31]}}, a};
      ext_b = {{32{signed_op & b[31]}}, b};
      prod  = ext_a * ext_b;
      // Divide on magnitudes and fix signs afterwards; this keeps
      // 0x80000000 / -1 well defined (quotient wraps to 0x80000000)
      neg_a = signed_op & a[31];
      neg_b = signed_op & b[31];
      mag_a = neg_a ? -a : a;
      mag_b = neg_b ? -b : b;
      dvs   = mag_b == 32'd0 ? 32'd1 : mag_b;
      q     = mag_a / dvs;
      r     = mag_a % dvs;
      quo   = (neg_a ^ neg_b) ? -q : q;
      rem   = neg_a ? -r : r;
      res    = is_div ? {rem, quo} : prod;
      res_we = !is_div || b != 32'd0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         HI_E_O   <= '0;
         LO_E_O   <= '0;
         Busy_E_O <= 1'b0;
         cnt      <= '0;
         res_q    <= '0;
         res_we_q <= 1'b0;
      end else if (Busy_E_O) begin
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            Busy_E_O <= 1'b0;
            if (res_we_q) {HI_E_O, LO_E_O} <= res_q;
         end
      end else if (Start_E_O) begin
         Busy_E_O <= 1'b1;
         cnt      <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         res_q    <= res;
         res_we_q <= res_we;
      end else if (!Req_I && is_mthi) begin
         HI_E_O <= a;
      end else if (!Req_I && is_mtlo) begin
         LO_E_O <= a;
      end
   end
endmodule

// File: tb/tb_md_unit_e.sv
// tb_md_unit_e: directed and random checks of md_unit_e against a HI/LO reference model.
module tb_md_unit_e;
   localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                          F_DIVU = 6'b011011, F_MFHI = 6'b010000, F_MTHI = 6'b010001,
                          F_MFLO = 6'b010010, F_MTLO = 6'b010011;
   logic        clk = 1'b0, reset = 1'b1, Req_I = 1'b0;
   logic [31:0] Instr_E_I = '0, RD1_E_I = '0, RD2_E_I = '0;
   logic        Start_E_O, Busy_E_O;
   logic [31:0] HI_E_O, LO_E_O, MDOut_E_O;
   logic [31:0] m_hi = '0, m_lo = '0;
   int          checks = 0, errors = 0;
   md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .Instr_E_I(Instr_E_I), .RD1_E_I(RD1_E_I), .RD2_E_I(RD2_E_I),
      .Req_I(Req_I), .Start_E_O(Start_E_O), .Busy_E_O(Busy_E_O), .HI_E_O(HI_E_O),
      .LO_E_O(LO_E_O), .MDOut_E_O(MDOut_E_O)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] rins(input logic [5:0] f);
      logic [19:0] mid;
      mid = 20'($urandom);
      return {6'b000000, mid, f};
   endfunction
   // Reference: HI/LO after an MD op, straight from the arithmetic definitions
   function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, sq, sr;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (f == F_MULT) begin
         p = 64'(sx * sy);
         {m_hi, m_lo} = p;
      end else if (f == F_MULTU) begin
         p = {32'd0, x} * {32'd0, y};
         {m_hi, m_lo} = p;
      end else if (y != 32'd0) begin
         if (f == F_DIV) begin
            sq = sx / sy;
            sr = sx % sy;
            m_lo = sq[31:0];
            m_hi = sr[31:0];
         end else begin
            m_lo = x / y;
            m_hi = x % y;
         end
      end
   endfunction
   task automatic do_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      int n;
      Instr_E_I = rins(f); RD1_E_I = x; RD2_E_I = y; Req_I = 1'b0;
      #1;
      chk("start", 32'(Start_E_O), 32'd1);
      cyc();
      Instr_E_I = '0;
      chk("busy_set", 32'(Busy_E_O), 32'd1);
      chk("hi_hold", HI_E_O, m_hi);
      n = 0;
      while (Busy_E_O === 1'b1 && n < 50) begin
         n++;
         cyc();
      end
      model(f, x, y);
      chk("busy_len", 32'(n), f[1] ? 32'd10 : 32'd5);
      chk("hi", HI_E_O, m_hi);
      chk("lo", LO_E_O, m_lo);
   endtask
   initial begin
      logic [5:0] ops [9];
      logic [5:0] f;
      logic [31:0] x, y;
      int n;
      ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO, 6'b100000};
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      Instr_E_I = rins(F_MFHI);
      #1;
      chk("rst_busy", 32'(Busy_E_O), 32'd0);
      chk("rst_hi", HI_E_O, 32'd0);
      chk("rst_lo", LO_E_O, 32'd0);
      chk("rst_mfhi", MDOut_E_O, 32'd0);
      Instr_E_I = rins(F_MFLO);
      #1;
      chk("rst_mflo", MDOut_E_O, 32'd0);
      do_op(F_MULT, 32'hFFFFFFFF, 32'd2);
      chk("mult_hi", HI_E_O, 32'hFFFFFFFF);
      chk("mult_lo", LO_E_O, 32'hFFFFFFFE);
      do_op(F_MULTU, 32'hFFFFFFFF, 32'd2);
      chk("multu_hi", HI_E_O, 32'h00000001);
      chk("multu_lo", LO_E_O, 32'hFFFFFFFE);
      do_op(F_DIV, 32'hFFFFFFF9, 32'd2);
      chk("div_lo", LO_E_O, 32'hFFFFFFFD);
      chk("div_hi", HI_E_O, 32'hFFFFFFFF);
      do_op(F_DIVU, 32'd7, 32'd0);
      chk("div0_lo", LO_E_O, 32'hFFFFFFFD);
      do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF);
      chk("ovf_lo", LO_E_O, 32'h80000000);
      chk("ovf_hi", HI_E_O, 32'd0);
      Instr_E_I = {6'b001000, 20'd0, F_MULT};
      #1;
      chk("inert_start", 32'(Start_E_O), 32'd0);
      Instr_E_I = rins(F_DIV); RD1_E_I = 32'd9; RD2_E_I = 32'd4; Req_I = 1'b1;
      #1;
      chk("req_start", 32'(Start_E_O), 32'd0);
      cyc();
      chk("req_busy", 32'(Busy_E_O), 32'd0);
      chk("req_hi", HI_E_O, m_hi);
      Instr_E_I = rins(F_MTLO); RD1_E_I = 32'h1234;
      cyc();
      chk("req_mtlo", LO_E_O, m_lo);
      Req_I = 1'b0;
      Instr_E_I = rins(F_MULT); RD1_E_I = 32'h12345678; RD2_E_I = 32'hFEDCBA98;
      cyc();
      chk("mid_start", 32'(Start_E_O), 32'd0);
      Instr_E_I = rins(F_MTHI); RD1_E_I = 32'hDEAD; Req_I = 1'b1;
      cyc();
      Req_I = 1'b0;
      cyc();
      Instr_E_I = '0;
      n = 2;
      while (Busy_E_O === 1'b1 && n < 50) begin
         n++;
         cyc();
      end
      model(F_MULT, 32'h12345678, 32'hFEDCBA98);
      chk("mid_len", 32'(n), 32'd5);
      chk("mid_hi", HI_E_O, m_hi);
      chk("mid_lo", LO_E_O, m_lo);
      Instr_E_I = rins(F_MTHI); RD1_E_I = 32'hABCD;
      cyc();
      m_hi = 32'hABCD;
      Instr_E_I = rins(F_MFHI);
      #1;
      chk("mthi_hi", HI_E_O, 32'hABCD);
      chk("mfhi_out", MDOut_E_O, 32'hABCD);
      Instr_E_I = rins(F_DIVU); RD1_E_I = 32'd100; RD2_E_I = 32'd7;
      cyc();
      Instr_E_I = '0;
      repeat (3) cyc();
      chk("pre_rst_busy", 32'(Busy_E_O), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      chk("mrst_busy", 32'(Busy_E_O), 32'd0);
      chk("mrst_hi", HI_E_O, 32'd0);
      chk("mrst_lo", LO_E_O, 32'd0);
      do_op(F_MULT, 32'd3, 32'hFFFFFFFB);
      chk("post_rst_lo", LO_E_O, 32'hFFFFFFF1);
      for (int i = 0; i < 40; i++) begin
         f = ops[$urandom_range(0, 8)];
         x = $urandom;
         y = $urandom_range(0, 4) == 0 ? 32'd0 : ($urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(1, 20)));
         if (f[5:2] == 4'b0110) begin
            do_op(f, x, y);
         end else if (f == F_MTHI || f == F_MTLO) begin
            Instr_E_I = rins(f); RD1_E_I = x;
            cyc();
            if (f == F_MTHI) m_hi = x; else m_lo = x;
            chk("rnd_mt_hi", HI_E_O, m_hi);
            chk("rnd_mt_lo", LO_E_O, m_lo);
         end else begin
            Instr_E_I = f == 6'b100000 ? rins(f) : rins(f);
            #1;
            chk("rnd_mf", MDOut_E_O, f == F_MFHI ? m_hi : f == F_MFLO ? m_lo : 32'd0);
            chk("rnd_nostart", 32'(Start_E_O), 32'd0);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
